// File: rtl/servo_pkg.sv
// Shared servo constants and angle/pulse helpers, reusable by any block that
// produces or consumes servo angles.
package servo_pkg;

   typedef logic [7:0] angle_t;

   localparam angle_t      MAX_ANGLE     = 8'd180;
   localparam angle_t      RESET_ANGLE   = 8'd90;
   localparam logic [15:0] MIN_PULSE_US  = 16'd500;
   localparam logic [15:0] PULSE_SPAN_US = 16'd2000;

   function automatic angle_t clamp_angle(input angle_t a);
      if (a > MAX_ANGLE) begin
         return MAX_ANGLE;
      end else begin
         return a;
      end
   endfunction

   // span/180 reduces to 100/9, so this floors exactly like angle*100/9
   function automatic logic [15:0] pulse_width_us(input angle_t a);
      logic [19:0] prod;
      prod = 20'(a) * 20'(PULSE_SPAN_US);
      return MIN_PULSE_US + 16'(prod / 20'(MAX_ANGLE));
   endfunction

endpackage

// File: rtl/us_tick.sv
// Free-running prescaler: oTick pulses on the last clock of every microsecond,
// oPhase0 marks the first clock of every microsecond.
module us_tick #(
   parameter int CLK_HZ = 50000000
) (
   input  logic iClk,
   input  logic iRst_n,
   output logic oTick,
   output logic oPhase0
);

   localparam int DIV = CLK_HZ / 1000000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next prescaler count, wrapping after DIV clocks
   always_comb begin
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Prescaler register
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign oTick   = (cnt_q == LAST);
   assign oPhase0 = (cnt_q == '0);

endmodule

// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator: angle latched once per frame, pulse 500..2500 us.
// Optional per-frame slew limiting is enabled by defining SERVO_SLEW_EN.
module servo_pwm
   import servo_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int PERIOD_US = 20000,
   parameter int SLEW_STEP = 1
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic [7:0] iAngle,
   output logic       oPwm,
   output logic       oFrameStart,
   output logic [7:0] oAngleApplied
);

   localparam int FW = ($clog2(PERIOD_US) > 12) ? $clog2(PERIOD_US) : 12;
   localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);

   logic          tick_s;
   logic          phase0_s;
   angle_t        target_s;
   angle_t        angle_next_s;

   logic [FW-1:0] frame_q, frame_d;
   logic [FW-1:0] width_q, width_d;
   angle_t        angle_q, angle_d;
   logic          pwm_q, pwm_d;
   logic          fs_q, fs_d;

   us_tick #(
      .CLK_HZ (CLK_HZ)
   ) u_us_tick (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .oTick   (tick_s),
      .oPhase0 (phase0_s)
   );

   assign target_s = clamp_angle(iAngle);

`ifdef SERVO_SLEW_EN
   localparam angle_t STEP = 8'(SLEW_STEP);

   angle_t diff_s;

   // Move toward the target by at most STEP degrees per frame
   always_comb begin
      diff_s       = 8'd0;
      angle_next_s = angle_q;
      if (target_s >= angle_q) begin
         diff_s = target_s - angle_q;
         if (diff_s > STEP) begin
            angle_next_s = angle_q + STEP;
         end else begin
            angle_next_s = target_s;
         end
      end else begin
         diff_s = angle_q - target_s;
         if (diff_s > STEP) begin
            angle_next_s = angle_q - STEP;
         end else begin
            angle_next_s = target_s;
         end
      end
   end
`else
   // Step size only matters when slewing is built in
   localparam int unused_slew_step = SLEW_STEP;

   assign angle_next_s = target_s;
`endif

   // Frame counter, angle latch and per-frame width; all change only at the wrap
   always_comb begin
      frame_d = frame_q;
      angle_d = angle_q;
      width_d = width_q;
      if (tick_s) begin
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            angle_d = angle_next_s;
            width_d = FW'(pulse_width_us(angle_next_s));
         end else begin
            frame_d = frame_q + FW'(1);
         end
      end else begin
         frame_d = frame_q;
      end
      pwm_d = (frame_q < width_q);
      fs_d  = phase0_s && (frame_q == '0);
   end

   // State and output registers; reset forces the line low immediately
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         frame_q <= '0;
         angle_q <= RESET_ANGLE;
         width_q <= FW'(pulse_width_us(RESET_ANGLE));
         pwm_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         frame_q <= frame_d;
         angle_q <= angle_d;
         width_q <= width_d;
         pwm_q   <= pwm_d;
         fs_q    <= fs_d;
      end
   end

   assign oPwm          = pwm_q;
   assign oFrameStart   = fs_q;
   assign oAngleApplied = angle_q;

endmodule
